data_mem_pipe: RTL and testbench
================================

// Module: data_mem_pipe
// PURPOSE
//  Parametrised, handshaked data memory for the multi-cycle/pipelined core. Accepts one load/store per
//  cycle (valid/ready), supports byte/half/word (and double when XLEN=64) with sign/zero extension,
//  registers read data (1-cycle latency), flags misaligned/illegal accesses, and buffers one response
//  so the core may stall. Sits between the MEM stage and the register-file writeback mux.
// PARAMETERS
//  XLEN       32      data width; 32 or 64 only
//  ADDR_WIDTH 32      byte-address width
//  MEM_WORDS  64      depth in XLEN-bit words; power of 2
//  INIT_FILE  ""      if non-empty, $readmemh preload; else contents undefined (no reset)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           async active-low reset
//  req_valid    in   1           request present
//  req_ready    out  1           request accepted when req_valid&&req_ready at posedge
//  req_we       in   1           1=store, 0=load
//  req_funct3   in   3           RISC-V funct3: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  req_addr     in   ADDR_WIDTH  byte address
//  req_wdata    in   XLEN        store data, low bytes used
//  resp_valid   out  1           response holding
//  resp_ready   in   1           consumer takes response at posedge when resp_valid&&resp_ready
//  resp_rdata   out  XLEN        extended load data; 0 for stores and faults
//  resp_fault   out  1           misaligned or illegal funct3; access suppressed
//  resp_is_load out  1           response belongs to a load
// BEHAVIOUR
//  - Reset (async, rst_n=0): resp_valid=0, resp_rdata=0, resp_fault=0, resp_is_load=0; memory untouched.
//  - req_ready = !resp_valid || resp_ready (1-entry output buffer; combinational ready, no req->ready path).
//  - States: EMPTY (resp_valid=0) / FULL (resp_valid=1). EMPTY+accept->FULL; FULL+resp_ready, no accept
//    ->EMPTY; FULL+resp_ready+accept->FULL with new response; FULL, !resp_ready -> hold all resp_* stable.
//  - Word index = req_addr[ADDR_WIDTH-1:log2(XLEN/8)] mod MEM_WORDS (wraps, never faults on range).
//  - Byte offset = low log2(XLEN/8) address bits; lane selects byte/half/word within the word.
//  - Alignment: H/HU need addr[0]=0; W/WU need addr[1:0]=0; D needs addr[2:0]=0. Else fault.
//  - Illegal: 111 always; 011,110 when XLEN=32; 100,101,110 with req_we=1. Illegal -> fault.
//  - Faulted request: no memory write, resp_rdata=0, resp_fault=1, still consumes one response slot.
//  - Store: byte-enable write at the accepting posedge, only selected lanes change; resp 1 cycle later.
//  - Load: memory read at accepting posedge, extended per funct3 (B/H/W sign, BU/HU/WU zero, D raw),
//    registered into resp_rdata; latency exactly 1 cycle from accept to resp_valid.
//  - Load following store to same word on next accept sees new data (write-first across cycles).
//  - Back-to-back: with resp_ready held 1, one request accepted and one response per cycle.
//  - Reset mid-operation: pending response dropped; writes committed before reset remain.
//  - Width rule: XLEN=32 -> rdata sign-extension to 32; XLEN=64 -> to 64 (LW sign-extends bits 63:32).
// TESTING
//  1. XLEN=32: SW 0xDEADBEEF @0x10, LW @0x10 -> resp_rdata=0xDEADBEEF, fault=0, 1-cycle latency.
//  2. SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW -> 0x80000000.
//  3. SH @0x21 -> fault=1, word 0x20 unchanged; funct3=111 load -> fault=1, rdata=0.
//  4. Hold resp_ready=0 two cycles after a load: req_ready=0, resp_* stable; release -> drains, next req accepted.
//  5. Address 0x100 (word 64) with MEM_WORDS=64 aliases word 0: SW @0x100 then LW @0x0 -> same data.
//  6. XLEN=64: SD 0x0123456789ABCDEF @0x8, LW @0xC -> 0x0000000001234567; LWU; assert rst_n mid-resp -> resp_valid=0 at once.

Source files
------------

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: handshaked load/store data memory with a one-entry response buffer.
// A request is accepted when req_valid && req_ready. The memory is read or written
// at the accepting edge, and the response is registered one cycle later. If the
// consumer stalls, the response buffer holds it and backpressures new requests.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_EMPTY | no response held; a request can always be accepted
// S_FULL  | response held on resp_*; a new request is accepted only when
//         | the held response drains in the same cycle
module data_mem_pipe #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 64,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_fault,
  output logic                  resp_is_load
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic                 accept;
  logic [IDX_W-1:0]     word_idx;
  logic [OFF_W-1:0]     byte_off;
  logic [1:0]           size;
  logic                 is_unsigned;
  logic                 illegal;
  logic                 misaligned;
  logic                 fault;
  logic                 do_write;
  logic [XLEN-1:0]      rd_word;
  logic [XLEN-1:0]      rd_shift;
  logic [XLEN-1:0]      size_mask;
  logic                 sign_bit;
  logic [XLEN-1:0]      load_ext;
  logic [NB-1:0]        be_base;
  logic [NB-1:0]        be;
  logic [XLEN-1:0]      wr_data_sh;
  logic                 unused_addr_hi;

  // Address bits above the word index wrap the memory and are intentionally ignored.
  assign unused_addr_hi = &{1'b0, req_addr[ADDR_WIDTH-1:OFF_W+IDX_W]};

  assign word_idx    = req_addr[OFF_W +: IDX_W];
  assign byte_off    = req_addr[OFF_W-1:0];
  assign size        = req_funct3[1:0];
  assign is_unsigned = req_funct3[2];
  assign accept      = req_valid && req_ready;

  // Detect funct3 encodings that are not legal for this width or direction.
  always_comb begin
    illegal = 1'b0;
    if (req_funct3 == 3'b111) illegal = 1'b1;
    if ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110))) illegal = 1'b1;
    if (req_we && req_funct3[2]) illegal = 1'b1;
  end

  // Detect accesses that are not naturally aligned to their size.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign fault    = illegal || misaligned;
  assign do_write = accept && req_we && !fault;

  // Load path: pick the addressed lane, then sign- or zero-extend it to XLEN.
  always_comb begin
    rd_word   = mem[word_idx];
    rd_shift  = rd_word >> {byte_off, 3'b000};
    size_mask = '1;
    sign_bit  = rd_shift[XLEN-1];
    case (size)
      2'd0: begin
        size_mask = XLEN'(8'hFF);
        sign_bit  = rd_shift[7];
      end
      2'd1: begin
        size_mask = XLEN'(16'hFFFF);
        sign_bit  = rd_shift[15];
      end
      2'd2: begin
        size_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit  = rd_shift[31];
      end
      default: begin
        size_mask = '1;
        sign_bit  = rd_shift[XLEN-1];
      end
    endcase
    load_ext = rd_shift & size_mask;
    if (!is_unsigned && sign_bit) load_ext = load_ext | ~size_mask;
  end

  // Store path: shift byte enables and data into the addressed lanes.
  always_comb begin
    be_base = '1;
    case (size)
      2'd0:    be_base = NB'(1'b1);
      2'd1:    be_base = NB'(2'b11);
      2'd2:    be_base = NB'(4'hF);
      default: be_base = '1;
    endcase
    be         = be_base << byte_off;
    wr_data_sh = req_wdata << {byte_off, 3'b000};
  end

  // Memory array: byte-enabled write at the accepting edge. No reset, so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_data_sh[8*b +: 8];
      end
    end
  end

  // Response payload register: capture the load result or the fault/store status on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata   <= '0;
      resp_fault   <= 1'b0;
      resp_is_load <= 1'b0;
    end else if (accept) begin
      resp_rdata   <= (req_we || fault) ? '0 : load_ext;
      resp_fault   <= fault;
      resp_is_load <= !req_we;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // FSM next state: fill on accept, drain when taken without a replacement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (resp_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM outputs: ready depends only on buffer state and resp_ready, never on req_valid.
  always_comb begin
    resp_valid = (state_q == S_FULL);
    req_ready  = (state_q == S_EMPTY) || resp_ready;
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: directed table, hand sequences and random traffic for data_mem_pipe
// (XLEN=32 instance), plus a directed sequence on an XLEN=64 instance.
module tb_data_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault, resp_is_load;

  logic        q64_valid, q64_ready, q64_we;
  logic [2:0]  q64_f3;
  logic [31:0] q64_addr;
  logic [63:0] q64_wdata;
  logic        r64_valid, r64_ready;
  logic [63:0] r64_rdata;
  logic        r64_fault, r64_is_load;

  data_mem_pipe #(.XLEN(32), .ADDR_WIDTH(32), .MEM_WORDS(64)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_is_load(resp_is_load)
  );

  data_mem_pipe #(.XLEN(64), .ADDR_WIDTH(32), .MEM_WORDS(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(q64_valid), .req_ready(q64_ready), .req_we(q64_we),
    .req_funct3(q64_f3), .req_addr(q64_addr), .req_wdata(q64_wdata),
    .resp_valid(r64_valid), .resp_ready(r64_ready), .resp_rdata(r64_rdata),
    .resp_fault(r64_fault), .resp_is_load(r64_is_load)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model for the XLEN=32 instance: byte-addressed memory (64 words x 4 bytes)
  logic [7:0]  mem_b [256];
  bit          m_valid;
  logic [31:0] m_rdata;
  bit          m_fault, m_is_load;

  function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = 1 << f3[1:0];
    if (f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
    int n, base;
    longint v;
    n    = 1 << f3[1:0];
    base = int'(addr % 256);
    v    = 0;
    for (int k = 0; k < n; k++) v = v | (longint'(mem_b[base+k]) << (8*k));
    if (!f3[2] && v[8*n-1]) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n, base;
    n    = 1 << f3[1:0];
    base = int'(addr % 256);
    for (int k = 0; k < n; k++) mem_b[base+k] = 8'((wd >> (8*k)) & 32'hFF);
  endtask

  // One clock cycle on the 32-bit instance; entered and left just after a negedge.
  task automatic step(input bit v, input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input bit rr);
    bit exp_ready, acc;
    req_valid = v; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; resp_ready = rr;
    #1;
    exp_ready = !m_valid || rr;
    chk("req_ready", req_ready, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) begin
      m_valid   = 1'b1;
      m_is_load = !we;
      if (m_bad(we, f3, addr)) begin
        m_fault = 1'b1;
        m_rdata = 32'h0;
      end else begin
        m_fault = 1'b0;
        if (we) begin
          m_store(f3, addr, wd);
          m_rdata = 32'h0;
        end else begin
          m_rdata = m_load(f3, addr);
        end
      end
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_fault", resp_fault, m_fault);
      chk("resp_is_load", resp_is_load, m_is_load);
    end
  endtask

  // One request on the 64-bit instance with constant expectations.
  task automatic req64(input string nm, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input bit exp_f);
    q64_valid = 1'b1; q64_we = we; q64_f3 = f3; q64_addr = addr; q64_wdata = wd; r64_ready = 1'b1;
    #1;
    chk({nm, "_ready"}, q64_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    q64_valid = 1'b0;
    chk({nm, "_valid"}, r64_valid, 1'b1);
    chk({nm, "_rdata"}, r64_rdata, exp_rd);
    chk({nm, "_fault"}, r64_fault, exp_f);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_fault;
  } vec_t;

  vec_t vecs [23];

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 3'b010, 32'h10,  32'h0,        32'h0,        1'b0};
    vecs[3]  = '{1'b1, 3'b000, 32'h13,  32'h80,       32'h0,        1'b0};
    vecs[4]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h80000000, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 32'h20,  32'h11223344, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 3'b001, 32'h21,  32'hAAAA,     32'h0,        1'b1};
    vecs[9]  = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h11223344, 1'b0};
    vecs[10] = '{1'b0, 3'b111, 32'h20,  32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 3'b001, 32'h22,  32'h0,        32'h00001122, 1'b0};
    vecs[14] = '{1'b0, 3'b101, 32'h0,   32'h0,        32'h0000F00D, 1'b0};
    vecs[15] = '{1'b0, 3'b001, 32'h0,   32'h0,        32'hFFFFF00D, 1'b0};
    vecs[16] = '{1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1};
    vecs[17] = '{1'b1, 3'b100, 32'h0,   32'h12,       32'h0,        1'b1};
    vecs[18] = '{1'b0, 3'b010, 32'h2,   32'h0,        32'h0,        1'b1};
    vecs[19] = '{1'b1, 3'b001, 32'h2,   32'hBEEF,     32'h0,        1'b0};
    vecs[20] = '{1'b0, 3'b010, 32'h0,   32'h0,        32'hBEEFF00D, 1'b0};
    vecs[21] = '{1'b0, 3'b110, 32'h0,   32'h0,        32'h0,        1'b1};
    vecs[22] = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h000000F0, 1'b0};

    m_valid = 1'b0; m_rdata = 32'h0; m_fault = 1'b0; m_is_load = 1'b0;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1;
    q64_valid = 1'b0; q64_we = 1'b0; q64_f3 = 3'b0; q64_addr = 32'h0; q64_wdata = 64'h0;
    r64_ready = 1'b1;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_fault", resp_fault, 1'b0);
    chk("rst_resp_is_load", resp_is_load, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst64_resp_valid", r64_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed table, back-to-back with resp_ready held high
    for (int i = 0; i < 23; i++) begin
      step(1'b1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1);
      chk($sformatf("vec%0d_valid", i), resp_valid, 1'b1);
      chk($sformatf("vec%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_fault", i), resp_fault, vecs[i].exp_fault);
      chk($sformatf("vec%0d_is_load", i), resp_is_load, !vecs[i].we);
    end
    step(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b1);
    chk("drain_empty", resp_valid, 1'b0);

    // consumer stall: response held, new request backpressured, then drained
    step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    step(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    chk("stall1_ready", req_ready, 1'b0);
    chk("stall1_rdata", resp_rdata, 32'h80000000);
    step(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    chk("stall2_ready", req_ready, 1'b0);
    chk("stall2_rdata", resp_rdata, 32'h80000000);
    step(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    chk("release_rdata", resp_rdata, 32'h11223344);
    step(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b1);

    // XLEN=64 instance
    req64("sd",    1'b1, 3'b011, 32'h8, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    req64("lw_c",  1'b0, 3'b010, 32'hC, 64'h0, 64'h0000000001234567, 1'b0);
    req64("lwu_c", 1'b0, 3'b110, 32'hC, 64'h0, 64'h0000000001234567, 1'b0);
    req64("lw_8",  1'b0, 3'b010, 32'h8, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0);
    req64("lwu_8", 1'b0, 3'b110, 32'h8, 64'h0, 64'h0000000089ABCDEF, 1'b0);
    req64("ld_8",  1'b0, 3'b011, 32'h8, 64'h0, 64'h0123456789ABCDEF, 1'b0);
    req64("lb_f",  1'b0, 3'b000, 32'hF, 64'h0, 64'h0000000000000001, 1'b0);
    req64("lh_a",  1'b0, 3'b001, 32'hA, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0);
    req64("ld_c",  1'b0, 3'b011, 32'hC, 64'h0, 64'h0, 1'b1);
    req64("sw_8",  1'b1, 3'b010, 32'h8, 64'hFFFFFFFF11112222, 64'h0, 1'b0);
    req64("ld_8b", 1'b0, 3'b011, 32'h8, 64'h0, 64'h0123456711112222, 1'b0);

    // reset while a 64-bit response is held
    q64_valid = 1'b1; q64_we = 1'b0; q64_f3 = 3'b011; q64_addr = 32'h8; r64_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q64_valid = 1'b0;
    chk("pre_rst64_valid", r64_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst64_valid", r64_valid, 1'b0);
    chk("mid_rst64_rdata", r64_rdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req64("post_rst64", 1'b0, 3'b011, 32'h8, 64'h0, 64'h0123456711112222, 1'b0);

    // reset while a 32-bit response is held
    step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    step(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    chk("mid_rst_valid", resp_valid, 1'b0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    chk("post_rst_rdata", resp_rdata, 32'h11223344);

    // random traffic: fill every word, then random requests and stalls
    for (int w = 0; w < 64; w++) step(1'b1, 1'b1, 3'b010, 32'(w*4), $urandom, 1'b1);
    for (int i = 0; i < 400; i++) begin
      bit          v, we, rr;
      logic [2:0]  f3;
      logic [31:0] addr;
      v    = ($urandom_range(0, 3) != 0);
      rr   = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 127) * 4);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(0, 3));
      step(v, we, f3, addr, $urandom, rr);
    end
    step(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
